// File: rtl/io_evt_pkg.sv
// io_evt_pkg: shared types and helpers for the event serializer.
// Holds default sizes and the round-robin search function.
package io_evt_pkg;

  localparam int unsigned N_EVT_DEF      = 128;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef logic [7:0] evt_id_t;

  // Returns {found, index} of the first set bit of vec[n-1:0],
  // scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  function automatic logic [8:0] rr_first(
    input logic [255:0] vec,
    input logic [7:0]   ptr,
    input int unsigned  n
  );
    logic [8:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < 256; k++) begin
      idx = {24'd0, ptr} + k;
      if (idx >= n) idx = idx - n;
      if (!res[8] && (k < n) && vec[idx[7:0]]) begin
        res = {1'b1, idx[7:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/io_evt_fifo.sv
// io_evt_fifo: small synchronous FIFO for event IDs.
// Power-of-two depth; push when full and pop when empty are ignored.
module io_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Qualify requests and compute pointer/occupancy updates.
  always_comb begin
    full_o  = (cnt_q == (AW+1)'(DEPTH));
    empty_o = (cnt_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Pointer and occupancy registers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful while counted.
  always_ff @(posedge sys_clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/io_evt_serializer.sv
// io_evt_serializer: latches event pulses, arbitrates round-robin,
// and streams event IDs through a FIFO with sticky overflow.
module io_evt_serializer
  import io_evt_pkg::*;
#(
  parameter int unsigned N_EVT      = N_EVT_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_ni,
  input  logic [N_EVT-1:0] evt_i,
  input  logic             clr_ovf_i,
  output logic             evt_valid_o,
  output logic [7:0]       evt_data_o,
  input  logic             evt_ready_i,
  output logic             ovf_o,
  output logic             err_o
);

  localparam int unsigned ID_W = $clog2(N_EVT);

  if (N_EVT < 2 || N_EVT > 256) begin : g_bad_n
    $error("N_EVT out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_d
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [N_EVT-1:0] pend_q, pend_d;
  logic [N_EVT-1:0] gnt_mask, drop_vec;
  logic [ID_W-1:0]  rr_q, rr_d, gnt_id;
  logic [8:0]       srch;
  logic             gnt_vld;
  logic             ovf_q, ovf_d, err_q, err_d;
  evt_id_t          last_q, head;
  logic             fifo_full, fifo_empty, pop;

  // Round-robin grant from the registered pending vector.
  always_comb begin
    srch     = rr_first(256'(pend_q), 8'(rr_q), N_EVT);
    gnt_vld  = srch[8] && !fifo_full;
    gnt_id   = srch[ID_W-1:0];
    gnt_mask = '0;
    rr_d     = rr_q;
    if (gnt_vld) begin
      gnt_mask[gnt_id] = 1'b1;
      rr_d = (gnt_id == ID_W'(N_EVT - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Pending update and drop detection; a re-arm on the granted
  // source is not a drop.
  always_comb begin
    drop_vec = evt_i & pend_q & ~gnt_mask;
    pend_d   = (pend_q & ~gnt_mask) | evt_i;
    err_d    = |drop_vec;
    ovf_d    = err_d | (ovf_q & ~clr_ovf_i);
  end

  // Control state registers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      pend_q <= '0;
      rr_q   <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      last_q <= '0;
    end else begin
      pend_q <= pend_d;
      rr_q   <= rr_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
      last_q <= evt_data_o;
    end
  end

  io_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .sys_clk_i  (sys_clk_i),
    .sys_rst_ni (sys_rst_ni),
    .push_i     (gnt_vld),
    .data_i     (evt_id_t'(gnt_id)),
    .pop_i      (pop),
    .data_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    ()
  );

  assign pop         = !fifo_empty && evt_ready_i;
  assign evt_valid_o = !fifo_empty;
  assign evt_data_o  = fifo_empty ? last_q : head;
  assign ovf_o       = ovf_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_io_evt_serializer.sv
// tb_io_evt_serializer: scoreboard bench with a queue-based
// reference model, directed scenarios and random traffic.
module tb_io_evt_serializer;

  localparam int N = 128;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] evt = '0;
  logic         clr = 1'b0;
  logic         ready = 1'b0;
  logic         valid;
  logic [7:0]   data;
  logic         ovf;
  logic         err;

  always #5 clk = ~clk;

  io_evt_serializer #(.N_EVT(N), .FIFO_DEPTH(D)) dut (
    .sys_clk_i   (clk),
    .sys_rst_ni  (rst_n),
    .evt_i       (evt),
    .clr_ovf_i   (clr),
    .evt_valid_o (valid),
    .evt_data_o  (data),
    .evt_ready_i (ready),
    .ovf_o       (ovf),
    .err_o       (err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending set, pointer, occupancy, ID scoreboard.
  bit mpend[N];
  int rr;
  int mcount;
  bit merr, movf;
  int exp_q[$];
  int rx_q[$];
  int mlast;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mpend[i] = 1'b0;
      rr = 0; mcount = 0; merr = 0; movf = 0;
      exp_q.delete();
    end else begin : step_model
      int g;
      bit drop, popm;
      popm = (mcount > 0) && ready;
      g = -1;
      if (mcount < D)
        for (int k = 0; k < N; k++)
          if (g < 0 && mpend[(rr + k) % N]) g = (rr + k) % N;
      drop = 0;
      for (int i = 0; i < N; i++)
        if (evt[i] && mpend[i] && i != g) drop = 1;
      for (int i = 0; i < N; i++) begin
        if (i == g) mpend[i] = 1'b0;
        if (evt[i]) mpend[i] = 1'b1;
      end
      if (g >= 0) begin
        exp_q.push_back(g);
        rr = (g + 1) % N;
      end
      mcount = mcount + (g >= 0 ? 1 : 0) - (popm ? 1 : 0);
      merr = drop;
      movf = drop | (movf & !clr);
    end
  end

  // Monitor: compare outputs each cycle, pop scoreboard on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      mlast = 0;
    end else begin
      chk("valid", valid, (mcount > 0));
      chk("err", err, merr);
      chk("ovf", ovf, movf);
      if (valid) begin
        chk("sb_empty", (exp_q.size() == 0), 0);
        if (exp_q.size() > 0) begin
          chk("data", data, exp_q[0]);
          mlast = exp_q[0];
          if (ready) rx_q.push_back(exp_q.pop_front());
        end
      end else begin
        chk("hold", data, mlast);
      end
    end
  end

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Apply inputs for one cycle; returns 2ns after the sampling edge.
  task automatic step(input logic [N-1:0] e, input logic r,
                      input logic c);
    evt = e; ready = r; clr = c;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) step('0, r, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] e;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(2, 1'b1);

    // single pulse latency
    step(oh(5), 1'b1, 1'b0);
    chk("lat_t1", valid, 0);
    step('0, 1'b1, 1'b0);
    chk("lat_t2", valid, 1);
    chk("lat_data", data, 5);
    step('0, 1'b1, 1'b0);
    chk("lat_t3", valid, 0);
    chk("lat_ovf", ovf, 0);
    idle(2, 1'b1);

    // multi-source with wrap
    do_reset();
    rx_q.delete();
    step(oh(3) | oh(67) | oh(127), 1'b1, 1'b0);
    idle(6, 1'b1);
    step(oh(1) | oh(100), 1'b1, 1'b0);
    idle(6, 1'b1);
    chk("wrap_n", rx_q.size(), 5);
    if (rx_q.size() == 5) begin
      chk("wrap0", rx_q[0], 3);
      chk("wrap1", rx_q[1], 67);
      chk("wrap2", rx_q[2], 127);
      chk("wrap3", rx_q[3], 1);
      chk("wrap4", rx_q[4], 100);
    end

    // fairness with continuous re-arm
    rx_q.delete();
    repeat (10) step(oh(0) | oh(1), 1'b1, 1'b0);
    idle(6, 1'b1);
    chk("fair_n", (rx_q.size() >= 8), 1);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      chk("fair_alt", rx_q[i], i % 2);

    // back-pressure, drop, overflow clear
    do_reset();
    rx_q.delete();
    step(oh(0) | oh(1) | oh(2) | oh(3) | oh(4) | oh(5), 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("bp_valid", valid, 1);
    chk("bp_head", data, 0);
    chk("bp_noerr", err, 0);
    step(oh(4), 1'b0, 1'b0);
    chk("bp_err", err, 1);
    chk("bp_ovf", ovf, 1);
    step(oh(5), 1'b0, 1'b1);
    chk("clr_drop_ovf", ovf, 1);
    step('0, 1'b0, 1'b1);
    chk("clr_ovf", ovf, 0);
    chk("clr_err", err, 0);
    idle(12, 1'b1);
    chk("bp_n", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      chk("bp_order", rx_q[i], i);

    // asynchronous reset with three IDs buffered
    rx_q.delete();
    step(oh(20) | oh(21) | oh(22), 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("rr_pre", valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_err", err, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(8, 1'b1);
    chk("arst_stale", rx_q.size(), 0);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      e = '0;
      if ($urandom_range(0, 2) == 0) e[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 3) == 0) e[$urandom_range(0, 7)] = 1'b1;
      step(e, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    idle(300, 1'b1);
    chk("drain", exp_q.size(), 0);
    chk("drain_valid", valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
